// File: rtl/dsp_jtag_pkg.sv
// Shared types for the DSP JTAG router: the IEEE 1149.1 TAP state encoding
// and the predicate that says when the chain mask may safely change.
package dsp_jtag_pkg;

  typedef enum logic [3:0] {
    TAP_EX2DR   = 4'h0,
    TAP_EX1DR   = 4'h1,
    TAP_SHDR    = 4'h2,
    TAP_PAUSEDR = 4'h3,
    TAP_SELIR   = 4'h4,
    TAP_UPDDR   = 4'h5,
    TAP_CAPDR   = 4'h6,
    TAP_SELDR   = 4'h7,
    TAP_EX2IR   = 4'h8,
    TAP_EX1IR   = 4'h9,
    TAP_SHIR    = 4'hA,
    TAP_PAUSEIR = 4'hB,
    TAP_RTI     = 4'hC,
    TAP_UPDIR   = 4'hD,
    TAP_CAPIR   = 4'hE,
    TAP_TLR     = 4'hF
  } tap_state_t;

  // Only the two idle states leave every DSP TAP in a place where reshaping the chain is harmless.
  function automatic logic is_safe_state(input tap_state_t s);
    return (s == TAP_TLR) || (s == TAP_RTI);
  endfunction

endpackage

// File: rtl/jtag_tap_tracker.sv
// Follows the host's TAP controller from the system clock domain by
// synchronising TCK/TMS/TRST and stepping a shadow 1149.1 state machine.
import dsp_jtag_pkg::*;

module jtag_tap_tracker #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tck,
  input  logic       tms,
  input  logic       trst_n,
  output logic [3:0] state,
  output logic       tck_rise,
  output logic       trst_hold
);

  logic [SYNC_STAGES-1:0] tck_sync;
  logic [SYNC_STAGES-1:0] tms_sync;
  logic [SYNC_STAGES-1:0] trst_sync;
  logic                   tck_prev;
  tap_state_t             cur_state;
  tap_state_t             nxt_state;

  // TMS rides the same pipeline depth as TCK so the sampled pair stays aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      tck_sync  <= '0;
      tms_sync  <= '0;
      trst_sync <= '0;
      tck_prev  <= 1'b0;
      cur_state <= TAP_TLR;
    end else begin
      tck_sync  <= {tck_sync[SYNC_STAGES-2:0], tck};
      tms_sync  <= {tms_sync[SYNC_STAGES-2:0], tms};
      trst_sync <= {trst_sync[SYNC_STAGES-2:0], trst_n};
      tck_prev  <= tck_sync[SYNC_STAGES-1];
      if (!trst_sync[SYNC_STAGES-1])
        cur_state <= TAP_TLR;
      else if (tck_rise)
        cur_state <= nxt_state;
    end
  end

  assign tck_rise  = tck_sync[SYNC_STAGES-1] & ~tck_prev;
  assign trst_hold = ~trst_sync[SYNC_STAGES-1];
  assign state     = cur_state;

  always_comb begin
    nxt_state = cur_state;
    unique case (cur_state)
      TAP_TLR:     nxt_state = tms_sync[SYNC_STAGES-1] ? TAP_TLR     : TAP_RTI;
      TAP_RTI:     nxt_state = tms_sync[SYNC_STAGES-1] ? TAP_SELDR   : TAP_RTI;
      TAP_SELDR:   nxt_state = tms_sync[SYNC_STAGES-1] ? TAP_SELIR   : TAP_CAPDR;
      TAP_CAPDR:   nxt_state = tms_sync[SYNC_STAGES-1] ? TAP_EX1DR   : TAP_SHDR;
      TAP_SHDR:    nxt_state = tms_sync[SYNC_STAGES-1] ? TAP_EX1DR   : TAP_SHDR;
      TAP_EX1DR:   nxt_state = tms_sync[SYNC_STAGES-1] ? TAP_UPDDR   : TAP_PAUSEDR;
      TAP_PAUSEDR: nxt_state = tms_sync[SYNC_STAGES-1] ? TAP_EX2DR   : TAP_PAUSEDR;
      TAP_EX2DR:   nxt_state = tms_sync[SYNC_STAGES-1] ? TAP_UPDDR   : TAP_SHDR;
      TAP_UPDDR:   nxt_state = tms_sync[SYNC_STAGES-1] ? TAP_SELDR   : TAP_RTI;
      TAP_SELIR:   nxt_state = tms_sync[SYNC_STAGES-1] ? TAP_TLR     : TAP_CAPIR;
      TAP_CAPIR:   nxt_state = tms_sync[SYNC_STAGES-1] ? TAP_EX1IR   : TAP_SHIR;
      TAP_SHIR:    nxt_state = tms_sync[SYNC_STAGES-1] ? TAP_EX1IR   : TAP_SHIR;
      TAP_EX1IR:   nxt_state = tms_sync[SYNC_STAGES-1] ? TAP_UPDIR   : TAP_PAUSEIR;
      TAP_PAUSEIR: nxt_state = tms_sync[SYNC_STAGES-1] ? TAP_EX2IR   : TAP_PAUSEIR;
      TAP_EX2IR:   nxt_state = tms_sync[SYNC_STAGES-1] ? TAP_UPDIR   : TAP_SHIR;
      TAP_UPDIR:   nxt_state = tms_sync[SYNC_STAGES-1] ? TAP_SELDR   : TAP_RTI;
      default:     nxt_state = TAP_TLR;
    endcase
  end

endmodule

// File: rtl/dsp_jtag_chain.sv
// JTAG router between the board header and N DSPs: a combinational daisy chain
// over the DSPs selected by ACTIVE, with mask changes held off until the TAP is idle.
import dsp_jtag_pkg::*;

module dsp_jtag_chain #(
  parameter int               N_DSP        = 2,
  parameter logic [N_DSP-1:0] ACTIVE_RESET = '1,
  parameter int               SYNC_STAGES  = 2,
  parameter int               EMU_FORWARD  = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             TCK_A,
  input  logic             TMS_A,
  input  logic             TDI_A,
  input  logic             TRST_A,
  output logic             TDO_A,
  output logic             EMU_A,
  output logic [N_DSP-1:0] DSP_TCK,
  output logic [N_DSP-1:0] DSP_TMS,
  output logic [N_DSP-1:0] DSP_TDI,
  output logic [N_DSP-1:0] DSP_TRST,
  input  logic [N_DSP-1:0] DSP_TDO,
  input  logic [N_DSP-1:0] DSP_EMU,
  input  logic [N_DSP-1:0] CFG_MASK,
  input  logic             CFG_WR,
  output logic [N_DSP-1:0] ACTIVE,
  output logic             CFG_BUSY,
  output logic [3:0]       TAP_STATE
);

  logic [N_DSP-1:0] active_q;
  logic [N_DSP-1:0] pending;
  logic             busy;
  logic [3:0]       tap_state;
  logic             tck_rise;
  logic             trst_hold;
  logic             commit_ok;
  logic [N_DSP-1:0] tdi_v;
  logic             tdo_v;
  logic             emu_and;

  jtag_tap_tracker #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_tracker (
    .clk      (CLK),
    .rst      (RST),
    .tck      (TCK_A),
    .tms      (TMS_A),
    .trst_n   (TRST_A),
    .state    (tap_state),
    .tck_rise (tck_rise),
    .trst_hold(trst_hold)
  );

  assign commit_ok = (is_safe_state(tap_state_t'(tap_state)) && !tck_rise) || trst_hold;

  // A write landing on the commit cycle wins, so the most recent request is never lost.
  always_ff @(posedge CLK) begin
    if (RST) begin
      active_q <= ACTIVE_RESET;
      pending  <= ACTIVE_RESET;
      busy     <= 1'b0;
    end else if (busy && commit_ok) begin
      active_q <= CFG_WR ? CFG_MASK : pending;
      pending  <= CFG_WR ? CFG_MASK : pending;
      busy     <= 1'b0;
    end else if (CFG_WR) begin
      pending  <= CFG_MASK;
      busy     <= 1'b1;
    end
  end

  // Walk the DSPs in index order, threading each active one's TDO into the next.
  always_comb begin
    tdi_v = '1;
    tdo_v = TDI_A;
    for (int k = 0; k < N_DSP; k++) begin
      if (active_q[k]) begin
        tdi_v[k] = tdo_v;
        tdo_v    = DSP_TDO[k];
      end
    end
  end

  assign emu_and   = &(DSP_EMU | ~active_q);

  assign TDO_A     = tdo_v;
  assign DSP_TDI   = tdi_v;
  assign DSP_TCK   = {N_DSP{TCK_A}};
  assign DSP_TMS   = {N_DSP{TMS_A}} | ~active_q;
  assign DSP_TRST  = {N_DSP{TRST_A}} & active_q;
  assign EMU_A     = (EMU_FORWARD != 0) ? emu_and : 1'b0;
  assign ACTIVE    = active_q;
  assign CFG_BUSY  = busy;
  assign TAP_STATE = tap_state;

endmodule

// File: tb/tb_dsp_jtag_chain.sv
// Directed scoreboard bench for dsp_jtag_chain with four DSPs and EMU forwarding on.
module tb_dsp_jtag_chain;

  logic       CLK = 1'b0;
  logic       RST;
  logic       TCK_A, TMS_A, TDI_A, TRST_A;
  logic       TDO_A, EMU_A;
  logic [3:0] DSP_TCK, DSP_TMS, DSP_TDI, DSP_TRST;
  logic [3:0] DSP_TDO, DSP_EMU;
  logic [3:0] CFG_MASK;
  logic       CFG_WR;
  logic [3:0] ACTIVE;
  logic       CFG_BUSY;
  logic [3:0] TAP_STATE;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q[$];
  logic        seen_0011 = 1'b0;
  logic [3:0]  act_model;

  dsp_jtag_chain #(
    .N_DSP(4), .ACTIVE_RESET(4'hF), .SYNC_STAGES(2), .EMU_FORWARD(1)
  ) dut (
    .CLK(CLK), .RST(RST),
    .TCK_A(TCK_A), .TMS_A(TMS_A), .TDI_A(TDI_A), .TRST_A(TRST_A),
    .TDO_A(TDO_A), .EMU_A(EMU_A),
    .DSP_TCK(DSP_TCK), .DSP_TMS(DSP_TMS), .DSP_TDI(DSP_TDI), .DSP_TRST(DSP_TRST),
    .DSP_TDO(DSP_TDO), .DSP_EMU(DSP_EMU),
    .CFG_MASK(CFG_MASK), .CFG_WR(CFG_WR),
    .ACTIVE(ACTIVE), .CFG_BUSY(CFG_BUSY), .TAP_STATE(TAP_STATE)
  );

  always #5 CLK = ~CLK;

  // Catches a superseded mask ever reaching ACTIVE.
  always @(posedge CLK) if (ACTIVE === 4'b0011) seen_0011 = 1'b1;

  task automatic expectVal(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed);
    logic [31:0] e;
    e = exp_q.pop_front();
    total++;
    assert (observed === e) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, e);
    end
  endtask

  // One full TCK period, 4 CLK low then 4 CLK high then 4 CLK low.
  task automatic applyStimulus(input logic tms);
    @(negedge CLK);
    TMS_A = tms;
    TCK_A = 1'b0;
    repeat (4) @(negedge CLK);
    TCK_A = 1'b1;
    repeat (4) @(negedge CLK);
    TCK_A = 1'b0;
    repeat (4) @(negedge CLK);
  endtask

  task automatic writeMask(input logic [3:0] m);
    @(negedge CLK);
    CFG_MASK = m;
    CFG_WR   = 1'b1;
    @(negedge CLK);
    CFG_WR   = 1'b0;
    #1;
  endtask

  task automatic checkState(input string tag, input logic [3:0] st, input logic [3:0] act, input logic bsy);
    expectVal(32'(st));  checkOutput({tag, "_tap"}, 32'(TAP_STATE));
    expectVal(32'(act)); checkOutput({tag, "_active"}, 32'(ACTIVE));
    expectVal(32'(bsy)); checkOutput({tag, "_busy"}, 32'(CFG_BUSY));
  endtask

  // Chain reference built from the intended mask: DSPs in index order, inactive ones skipped.
  task automatic checkRouting(input string tag);
    logic [3:0] pats [4];
    logic [3:0] e_tdi;
    logic       src;
    pats[0] = 4'b0101; pats[1] = 4'b1010; pats[2] = 4'b0011; pats[3] = 4'b1110;
    for (int p = 0; p < 4; p++) begin
      for (int t = 0; t < 2; t++) begin
        DSP_TDO = pats[p];
        TDI_A   = t[0];
        #1;
        e_tdi = 4'hF;
        src   = TDI_A;
        for (int k = 0; k < 4; k++) begin
          if (act_model[k]) begin
            e_tdi[k] = src;
            src      = pats[p][k];
          end
        end
        expectVal(32'(e_tdi)); checkOutput({tag, "_dsp_tdi"}, 32'(DSP_TDI));
        expectVal(32'(src));   checkOutput({tag, "_tdo_a"}, 32'(TDO_A));
      end
    end
  endtask

  initial begin
    RST = 1'b1; TCK_A = 1'b0; TMS_A = 1'b1; TDI_A = 1'b0; TRST_A = 1'b1;
    DSP_TDO = 4'h0; DSP_EMU = 4'hF; CFG_MASK = 4'h0; CFG_WR = 1'b0;
    act_model = 4'hF;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    repeat (4) @(negedge CLK);
    #1;
    $display("[TB] reset and idle");
    checkState("reset", 4'hF, 4'hF, 1'b0);

    for (int i = 0; i < 5; i++) applyStimulus(1'b1);
    applyStimulus(1'b0);
    #1;
    checkState("to_rti", 4'hC, 4'hF, 1'b0);
    DSP_TDO = 4'b1001; TDI_A = 1'b0; #1;
    expectVal(32'(DSP_TDO[3])); checkOutput("rti_tdo_is_dsp3", 32'(TDO_A));
    expectVal(32'(DSP_TDO[0])); checkOutput("rti_tdi1_is_tdo0", 32'(DSP_TDI[1]));
    checkRouting("full");

    $display("[TB] safe commit");
    writeMask(4'b0101);
    checkState("safe_wr", 4'hC, 4'hF, 1'b1);
    @(negedge CLK); #1;
    act_model = 4'b0101;
    checkState("safe_commit", 4'hC, 4'b0101, 1'b0);
    DSP_TDO = 4'b0001; #1;
    expectVal(32'(1)); checkOutput("safe_tdi2_is_tdo0", 32'(DSP_TDI[2]));
    DSP_TDO = 4'b0100; #1;
    expectVal(32'(1)); checkOutput("safe_tdo_is_dsp2", 32'(TDO_A));
    expectVal(32'(4'b0101)); checkOutput("safe_trst", 32'(DSP_TRST));
    expectVal(32'(4'b1010)); checkOutput("safe_tms", 32'(DSP_TMS));
    TCK_A = 1'b1; #1;
    expectVal(32'(4'hF)); checkOutput("tck_fanout", 32'(DSP_TCK));
    TCK_A = 1'b0;
    repeat (6) @(negedge CLK);
    checkRouting("m0101");

    $display("[TB] deferred commit");
    applyStimulus(1'b1); applyStimulus(1'b0); applyStimulus(1'b0);
    #1;
    checkState("to_shdr", 4'h2, 4'b0101, 1'b0);
    writeMask(4'b0010);
    checkState("shdr_wr", 4'h2, 4'b0101, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0);
      #1;
      checkState("shifting", 4'h2, 4'b0101, 1'b1);
    end
    applyStimulus(1'b1); #1;
    checkState("ex1dr", 4'h1, 4'b0101, 1'b1);
    applyStimulus(1'b1); #1;
    checkState("upddr", 4'h5, 4'b0101, 1'b1);
    applyStimulus(1'b0); #1;
    act_model = 4'b0010;
    checkState("deferred_commit", 4'hC, 4'b0010, 1'b0);

    $display("[TB] overwrite in PauseIR");
    applyStimulus(1'b1); applyStimulus(1'b1); applyStimulus(1'b0);
    applyStimulus(1'b0); applyStimulus(1'b1); applyStimulus(1'b0);
    #1;
    checkState("to_pauseir", 4'hB, 4'b0010, 1'b0);
    writeMask(4'b0011);
    repeat (2) @(negedge CLK); #1;
    checkState("pause_wr1", 4'hB, 4'b0010, 1'b1);
    writeMask(4'b1000);
    repeat (2) @(negedge CLK); #1;
    checkState("pause_wr2", 4'hB, 4'b0010, 1'b1);
    applyStimulus(1'b1); applyStimulus(1'b1); applyStimulus(1'b0);
    #1;
    act_model = 4'b1000;
    checkState("overwrite_commit", 4'hC, 4'b1000, 1'b0);
    expectVal(32'(0)); checkOutput("never_0011", 32'(seen_0011));

    $display("[TB] empty mask in TLR");
    for (int i = 0; i < 5; i++) applyStimulus(1'b1);
    writeMask(4'b0000);
    @(negedge CLK); #1;
    act_model = 4'b0000;
    checkState("empty", 4'hF, 4'h0, 1'b0);
    checkRouting("bypass");
    expectVal(32'(4'h0)); checkOutput("empty_trst", 32'(DSP_TRST));
    expectVal(32'(0)); checkOutput("empty_emu", 32'(EMU_A === 1'b0 ? 1'b1 : 1'b0));

    $display("[TB] TRST override");
    applyStimulus(1'b0); applyStimulus(1'b1); applyStimulus(1'b0); applyStimulus(1'b0);
    writeMask(4'b0110);
    checkState("trst_pending", 4'h2, 4'h0, 1'b1);
    @(negedge CLK);
    TRST_A = 1'b0;
    repeat (4) @(negedge CLK); #1;
    act_model = 4'b0110;
    checkState("trst_commit", 4'hF, 4'b0110, 1'b0);
    expectVal(32'(4'h0)); checkOutput("trst_low_dsp", 32'(DSP_TRST));
    TRST_A = 1'b1;
    repeat (4) @(negedge CLK); #1;
    expectVal(32'(4'b0110)); checkOutput("trst_high_dsp", 32'(DSP_TRST));

    $display("[TB] EMU forwarding");
    writeMask(4'b0001);
    @(negedge CLK); #1;
    act_model = 4'b0001;
    checkState("emu_mask", 4'hF, 4'b0001, 1'b0);
    DSP_EMU = 4'b1011; #1;
    expectVal(32'(1)); checkOutput("emu_inactive_low", 32'(EMU_A));
    DSP_EMU = 4'b1110; #1;
    expectVal(32'(0)); checkOutput("emu_active_low", 32'(EMU_A));
    DSP_EMU = 4'b1111; #1;
    expectVal(32'(1)); checkOutput("emu_idle", 32'(EMU_A));

    $display("[TB] reset while busy");
    applyStimulus(1'b0); applyStimulus(1'b1); applyStimulus(1'b0); applyStimulus(1'b0);
    writeMask(4'b0100);
    checkState("rst_pending", 4'h2, 4'b0001, 1'b1);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    #1;
    checkState("rst_mid", 4'hF, 4'hF, 1'b0);
    repeat (6) @(negedge CLK); #1;
    checkState("rst_settled", 4'hF, 4'hF, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
